vram_arbiter: RTL

Single-port video RAM arbiter between the VGA scan-out fetch path and the host draw port (separate read and write channels). It sits between the pixel-fetch logic driven by `vgactrl`'s hcount/vcount and one synchronous-read block RAM. It runs in the pixel clock domain (25 MHz or 40 MHz). The display port has strict priority, subject to a bounded-starvation guard for the host. Host read and write requests are alternated round-robin.

---
 rtl/vram_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has priority, host read/write alternate,
// with a bounded-starvation force for the host. Optional counters: VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_valid,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ready,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_disp_stall,
  output logic [15:0]       stat_force
`endif
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DISP = 2'd1;
  localparam logic [1:0] OWN_RD   = 2'd2;
  localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);

  logic       force_q;
  logic       last_host;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic [1:0] own_s1;
  logic [1:0] own_s2;
  logic       host_pend;
  logic       host_xfer;
  logic       pick_wr;
  logic       pick_rd;

  // last_host = 1 means the read channel was served last, so a write wins the tie
  assign host_pend  = wr_valid | rd_valid;
  assign pick_wr    = wr_valid & (~rd_valid | last_host);
  assign pick_rd    = rd_valid & ~pick_wr;
  assign disp_ready = disp_valid & ~force_q;
  assign wr_ready   = pick_wr & ~disp_ready;
  assign rd_ready   = pick_rd & ~disp_ready;
  assign host_xfer  = wr_ready | rd_ready;

  always_comb begin
    wait_nxt = wait_cnt;
    if (host_xfer)
      wait_nxt = 8'd0;
    else if (host_pend && (wait_cnt != MAX_W))
      wait_nxt = wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= 8'd0;
      force_q   <= 1'b0;
      last_host <= 1'b1;
    end else begin
      wait_cnt <= wait_nxt;
      force_q  <= (wait_nxt == MAX_W);
      if (wr_ready)
        last_host <= 1'b0;
      else if (rd_ready)
        last_host <= 1'b1;
    end
  end

  // RAM command stage; address/data hold when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= disp_ready | wr_ready | rd_ready;
      mem_we <= wr_ready;
      if (wr_ready) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (rd_ready) begin
        mem_addr <= rd_addr;
      end else if (disp_ready) begin
        mem_addr <= disp_addr;
      end
    end
  end

  // Read-owner tags travel alongside the RAM's one-cycle read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_s1 <= OWN_NONE;
      own_s2 <= OWN_NONE;
    end else begin
      own_s1 <= disp_ready ? OWN_DISP : (rd_ready ? OWN_RD : OWN_NONE);
      own_s2 <= own_s1;
    end
  end

  assign disp_rdata  = mem_rdata;
  assign rd_data     = mem_rdata;
  assign disp_rvalid = (own_s2 == OWN_DISP);
  assign rd_rvalid   = (own_s2 == OWN_RD);

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_disp_stall <= 16'd0;
      stat_force      <= 16'd0;
    end else begin
      if (disp_valid && !disp_ready && (stat_disp_stall != 16'hFFFF))
        stat_disp_stall <= stat_disp_stall + 16'd1;
      if (force_q && host_xfer && (stat_force != 16'hFFFF))
        stat_force <= stat_force + 16'd1;
    end
  end
`endif

endmodule
